// File: rtl/beep_sequencer.sv
// Song-playing tone generator: steps through a small memory of {period, beats}
// entries and drives a square wave for a fixed time per note, with an optional gap.
module beep_sequencer #(
    parameter int PERIOD_W    = 17,
    parameter int BEAT_W      = 4,
    parameter int DEPTH       = 32,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [BEAT_W-1:0]   wr_beats,
    output logic                beep,
    output logic                playing,
    output logic [ADDR_W-1:0]   note_idx,
    output logic                done
);

    localparam int ENTRY_W  = PERIOD_W + BEAT_W;
    localparam int LAST_MAX = DEPTH - 1;
    localparam int CYC_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CYC_W-1:0]    CYC_LAST_V = CYC_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST_V = GAP_W'(GAP_LAST);
    localparam logic [ADDR_W-1:0]   LAST_MAX_V = ADDR_W'(LAST_MAX);
    localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);
    localparam logic [BEAT_W-1:0]   ONE_B      = BEAT_W'(1);
    localparam logic [CYC_W-1:0]    ONE_C      = CYC_W'(1);
    localparam logic [GAP_W-1:0]    ONE_G      = GAP_W'(1);
    localparam logic [ADDR_W-1:0]   ONE_A      = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Out-of-range final index collapses onto the last physical entry.
    function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] idx);
        if ({1'b0, idx} > {1'b0, LAST_MAX_V}) begin
            return LAST_MAX_V;
        end else begin
            return idx;
        end
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   note_idx_r, note_idx_s;
    logic [ADDR_W-1:0]   last_r, last_s;
    logic [PERIOD_W-1:0] period_r, period_s;
    logic [BEAT_W-1:0]   beats_r, beats_s;
    logic [BEAT_W-1:0]   beat_r, beat_s;
    logic [CYC_W-1:0]    cyc_r, cyc_s;
    logic [PERIOD_W-1:0] tone_r, tone_s;
    logic [GAP_W-1:0]    gap_r, gap_s;
    logic                beep_r, beep_s;
    logic                playing_r, playing_s;
    logic                done_r, done_s;
    logic                decide_s;
    logic                load_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic [ENTRY_W-1:0]  entry_s;

    // Song memory write port; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} <= {1'b0, LAST_MAX_V})) begin
            mem[wr_addr] <= {wr_period, wr_beats};
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_s     = state_r;
        note_idx_s  = note_idx_r;
        last_s      = last_r;
        period_s    = period_r;
        beats_s     = beats_r;
        beat_s      = beat_r;
        cyc_s       = cyc_r;
        tone_s      = tone_r;
        gap_s       = gap_r;
        done_s      = 1'b0;
        decide_s    = 1'b0;
        load_s      = 1'b0;
        load_addr_s = {ADDR_W{1'b0}};

        if (stop) begin
            state_s = IDLE;
            beat_s  = {BEAT_W{1'b0}};
            cyc_s   = {CYC_W{1'b0}};
            tone_s  = {PERIOD_W{1'b0}};
            gap_s   = {GAP_W{1'b0}};
        end else if (start) begin
            last_s      = clamp_last(last_idx);
            load_s      = 1'b1;
            load_addr_s = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                PLAY: begin
                    if ((period_r == {PERIOD_W{1'b0}}) || (tone_r == period_r - ONE_P)) begin
                        tone_s = {PERIOD_W{1'b0}};
                    end else begin
                        tone_s = tone_r + ONE_P;
                    end
                    // Note length depends only on beats, never on the tone period.
                    if (cyc_r == CYC_LAST_V) begin
                        cyc_s = {CYC_W{1'b0}};
                        if (beat_r == beats_r - ONE_B) begin
                            beat_s = {BEAT_W{1'b0}};
                            if (GAP_CYCLES > 0) begin
                                state_s = GAP;
                                gap_s   = {GAP_W{1'b0}};
                            end else begin
                                decide_s = 1'b1;
                            end
                        end else begin
                            beat_s = beat_r + ONE_B;
                        end
                    end else begin
                        cyc_s = cyc_r + ONE_C;
                    end
                end
                GAP: begin
                    if (gap_r == GAP_LAST_V) begin
                        decide_s = 1'b1;
                    end else begin
                        gap_s = gap_r + ONE_G;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase

            if (decide_s) begin
                if (note_idx_r < last_r) begin
                    load_s      = 1'b1;
                    load_addr_s = note_idx_r + ONE_A;
                end else if (loop_en) begin
                    load_s      = 1'b1;
                    load_addr_s = {ADDR_W{1'b0}};
                end else begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end
            end else begin
                done_s = 1'b0;
            end
        end

        // Entries are read from memory only here, so in-flight writes wait for the next load.
        entry_s = mem[load_addr_s];
        if (load_s) begin
            state_s    = PLAY;
            note_idx_s = load_addr_s;
            period_s   = entry_s[ENTRY_W-1:BEAT_W];
            beats_s    = (entry_s[BEAT_W-1:0] == {BEAT_W{1'b0}}) ? ONE_B : entry_s[BEAT_W-1:0];
            beat_s     = {BEAT_W{1'b0}};
            cyc_s      = {CYC_W{1'b0}};
            tone_s     = {PERIOD_W{1'b0}};
            gap_s      = {GAP_W{1'b0}};
        end else begin
            period_s = period_r;
        end

        playing_s = (state_s != IDLE);
        beep_s    = (state_s == PLAY) && (period_s != {PERIOD_W{1'b0}}) &&
                    (tone_s >= (period_s >> 1));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            note_idx_r <= {ADDR_W{1'b0}};
            last_r     <= {ADDR_W{1'b0}};
            period_r   <= {PERIOD_W{1'b0}};
            beats_r    <= {BEAT_W{1'b0}};
            beat_r     <= {BEAT_W{1'b0}};
            cyc_r      <= {CYC_W{1'b0}};
            tone_r     <= {PERIOD_W{1'b0}};
            gap_r      <= {GAP_W{1'b0}};
            beep_r     <= 1'b0;
            playing_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            note_idx_r <= note_idx_s;
            last_r     <= last_s;
            period_r   <= period_s;
            beats_r    <= beats_s;
            beat_r     <= beat_s;
            cyc_r      <= cyc_s;
            tone_r     <= tone_s;
            gap_r      <= gap_s;
            beep_r     <= beep_s;
            playing_r  <= playing_s;
            done_r     <= done_s;
        end
    end

    assign beep     = beep_r;
    assign playing  = playing_r;
    assign note_idx = note_idx_r;
    assign done     = done_r;

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: time-based song model checked every cycle,
// directed waveform scenarios with literal expectations, then random traffic.
module tb_beep_sequencer;

    localparam int PW    = 8;
    localparam int BW    = 2;
    localparam int DEPTH = 4;
    localparam int BC    = 8;
    localparam int GC    = 2;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] last_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_period;
    logic [BW-1:0] wr_beats;
    logic          beep;
    logic          playing;
    logic [AW-1:0] note_idx;
    logic          done;

    always #5 clk = ~clk;

    beep_sequencer #(
        .PERIOD_W(PW), .BEAT_W(BW), .DEPTH(DEPTH), .BEAT_CYCLES(BC), .GAP_CYCLES(GC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
        .wr_beats(wr_beats), .beep(beep), .playing(playing), .note_idx(note_idx), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase (0 idle, 1 play, 2 gap), elapsed time in phase, note length.
    int m_state = 0, m_idx = 0, m_last = 0, m_period = 0, m_dur = 0, m_t = 0;
    bit m_done = 1'b0;
    int m_mem_p [DEPTH];
    int m_mem_b [DEPTH];

    task automatic m_load(input int a);
        m_state  = 1;
        m_idx    = a;
        m_period = m_mem_p[a];
        m_dur    = ((m_mem_b[a] == 0) ? 1 : m_mem_b[a]) * BC;
        m_t      = 0;
    endtask

    task automatic m_decide();
        if (m_idx < m_last) m_load(m_idx + 1);
        else if (loop_en) m_load(0);
        else begin
            m_state = 0;
            m_done  = 1'b1;
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_state = 0; m_idx = 0; m_t = 0; m_period = 0;
        end else if (stop) begin
            m_state = 0;
        end else if (start) begin
            m_last = (int'(last_idx) > DEPTH - 1) ? DEPTH - 1 : int'(last_idx);
            m_load(0);
        end else if (m_state == 1) begin
            m_t++;
            if (m_t == m_dur) begin
                if (GC > 0) begin
                    m_state = 2;
                    m_t     = 0;
                end else m_decide();
            end
        end else if (m_state == 2) begin
            m_t++;
            if (m_t == GC) m_decide();
        end
        if (wr_en) begin
            m_mem_p[wr_addr] = int'(wr_period);
            m_mem_b[wr_addr] = int'(wr_beats);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            int eb;
            @(posedge clk);
            model_step();
            #1;
            eb = (m_state == 1 && m_period != 0 && (m_t % m_period) >= m_period / 2) ? 1 : 0;
            check("beep", int'(beep), eb);
            check("playing", int'(playing), (m_state != 0) ? 1 : 0);
            check("note_idx", int'(note_idx), m_idx);
            check("done", int'(done), int'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int p, input int b);
        wr_en     = 1'b1;
        wr_addr   = AW'(a);
        wr_period = PW'(p);
        wr_beats  = BW'(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic play_capture(input int n, output logic [63:0] bits,
                                output int pc, output int dc, output int hi);
        bits = 64'd0; pc = 0; dc = 0; hi = 0;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            bits = {bits[62:0], beep};
            pc += int'(playing);
            dc += int'(done);
            hi += int'(beep);
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_beep"}, int'(beep), 0);
        check({tag, "_playing"}, int'(playing), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_note_idx"}, int'(note_idx), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [63:0] bits;
    int pc, dc, hi;

    initial begin
        int  saw_one, saw_wrap, dcount, got_done, idx_at_done;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0;
        wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_beats = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem_p[i] = 0;
            m_mem_b[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_beep", int'(beep), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_note_idx", int'(note_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 0);

        // Single note {4,1}: 8 play + 2 gap, beep 0011 0011, done once.
        write_entry(0, 4, 1);
        last_idx = 2'd0;
        play_capture(14, bits, pc, dc, hi);
        check("s1_wave", int'(bits[13:0]), int'(14'b00110011000000));
        check("s1_playing_cycles", pc, 10);
        check("s1_done_count", dc, 1);

        // Three notes: 16 + 8 + 8 play cycles, each with a 2-cycle gap.
        write_entry(0, 4, 2);
        write_entry(1, 0, 1);
        write_entry(2, 6, 0);
        last_idx = 2'd2;
        play_capture(42, bits, pc, dc, hi);
        check("s2_playing_cycles", pc, 38);
        check("s2_beep_high", hi, 11);
        check("s2_done_count", dc, 1);

        // Simultaneous start and stop mid-note.
        write_entry(0, 4, 3);
        last_idx = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("s3_playing", int'(playing), 0);
        check("s3_beep", int'(beep), 0);
        check("s3_done", int'(done), 0);
        repeat (3) tick();

        // Reset mid-note; memory survives and replay matches the single-note waveform.
        write_entry(0, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        async_reset_pulse("s4_async");
        play_capture(14, bits, pc, dc, hi);
        check("s4_wave", int'(bits[13:0]), int'(14'b00110011000000));
        check("s4_playing_cycles", pc, 10);
        check("s4_done_count", dc, 1);

        // Looping two-entry song, with entry 0 rewritten while it plays.
        write_entry(0, 2, 1);
        write_entry(1, 3, 0);
        last_idx = 2'd1;
        loop_en  = 1'b1;
        start    = 1'b1;
        saw_one = 0; saw_wrap = 0; dcount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            start = 1'b0;
            if (i == 3) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_period = 8'd4; wr_beats = 2'd1;
            end else wr_en = 1'b0;
            if (note_idx == 2'd1) saw_one = 1;
            if (saw_one == 1 && note_idx == 2'd0 && playing) saw_wrap = 1;
            dcount += int'(done);
        end
        wr_en = 1'b0;
        check("s5_wrapped", saw_wrap, 1);
        check("s5_no_done", dcount, 0);
        loop_en = 1'b0;
        got_done = 0; idx_at_done = -1;
        for (int i = 0; i < 80 && got_done == 0; i++) begin
            tick();
            if (done) begin
                got_done    = 1;
                idx_at_done = int'(note_idx);
            end
        end
        check("s5_done_seen", got_done, 1);
        check("s5_done_idx", idx_at_done, 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_period = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 255))
                                                    : PW'($urandom_range(0, 9));
            wr_beats  = BW'($urandom_range(0, 3));
            start     = ($urandom_range(0, 59) == 0);
            stop      = ($urandom_range(0, 199) == 0);
            last_idx  = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            tick();
            if ($urandom_range(0, 799) == 0) begin
                wr_en = 1'b0; start = 1'b0; stop = 1'b0;
                async_reset_pulse("rnd_async");
            end
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
